alu_step_ctrl: RTL and testbench
================================

# alu_step_ctrl

Parametrised control-step sequencer that drives the datapath's bus-select and register-load strobes through one instruction fetch plus one register-register ALU instruction (T0–T6). It replaces hand-sequenced per-opcode benches with a single FSM that decodes the IR register fields into one-hot strobes. It adds a memory-ready wait state and the two-step HI/LO write-back for mul/div. It sits beside `datapath`, with its outputs wired to the same-named datapath controls.

## Interface
- `NREGS`, 16: number of general registers (width of one-hot strobes).
- `RIDX_W`, 4: register index field width; must satisfy 2**RIDX_W >= NREGS.
- `OPC_W`, 5: opcode field width.
- `IR_W`, 32: instruction width. Fields from the MSB: opcode, ra, rb, rc.
- `OPC_MUL`, 5'b01111: opcode that takes the HI/LO write-back path.
- `OPC_DIV`, 5'b10000: opcode that takes the HI/LO write-back path.
- `IMM_BIT`, 0: IR bit flagging immediate form (used only with the macro).

Ports:
- `Clock` in 1: single clock, rising edge.
- `clear` in 1: asynchronous, active-low reset.
- `start` in 1: begin one instruction; sampled in IDLE.
- `mem_rdy` in 1: memory read data valid.
- `ir` in IR_W: datapath IR contents.
- `busy` out 1: high in any state except IDLE.
- `done` out 1: one-cycle pulse on the last step.
- `step` out 3: current step (T0=0 … T6=6; 7 in IDLE).
- `opcode` out OPC_W: ALU operation select.
- `r_in` out NREGS: one-hot register load strobes.
- `r_out` out NREGS: one-hot register bus-drive strobes.
- `pc_out`, `mar_in`, `inc_pc`, `z_in`, `zlow_out`, `zhigh_out`, `pc_in`, `read`, `mdr_in`, `mdr_out`, `ir_in`, `y_in`, `hi_in`, `lo_in`, `c_out` out 1 each: datapath controls.

## Operation
- States: IDLE, T0, T1, T2, T3, T4, T5, T6. All outputs are decoded from the state register and the latched fields only; there is no combinational path from any input to any output.
- IDLE → T0 when `start`=1; otherwise stay in IDLE. `start` in any other state is ignored.
- T0: `pc_out`, `mar_in`, `inc_pc`, `z_in`.
- T1:
  - `read` and `mdr_in` are held every cycle while in T1.
  - `zlow_out` and `pc_in` are asserted on the first T1 cycle only.
  - Stay in T1 while `mem_rdy`=0; go to T2 on the cycle `mem_rdy`=1.
- T2: `mdr_out`, `ir_in`. ra, rb, rc and the opcode are latched from `ir` at the end of T2 and held until IDLE.
- T3: `r_out[rb]`, `y_in`.
- T4: `r_out[rc]`, `z_in`; `opcode` = latched opcode.
  - `opcode` holds that value through T5/T6.
  - `opcode` is 0 in all other states.
- T5, normal opcodes: `zlow_out`, `r_in[ra]`, `done`; then → IDLE.
- T5, `OPC_MUL`/`OPC_DIV`: `zlow_out`, `lo_in`; then → T6.
- T6: `zhigh_out`, `hi_in`, `done`; then → IDLE.
- Any register index >= NREGS asserts no `r_in`/`r_out` bit. Nothing else changes.
- ra equal to rb or rc is legal; there is no special handling.
- At most one `r_out` bit is high at any time.

## Timing
- While `clear`=0, the state is IDLE, `step`=7, and every other output is 0. This takes effect asynchronously, including mid-instruction. Nothing is resumed after release.
- `busy` goes high the cycle after `start` is sampled.
- Latency with `mem_rdy` already high: 6 cycles from T0 to `done` for normal opcodes, 7 for mul/div. Each `mem_rdy`=0 cycle in T1 adds one cycle.
- Back-to-back: if `start`=1 in the cycle after `done`, T0 follows immediately, leaving a single IDLE cycle.

## Configuration
- `ALU_STEP_IMM_EN` defined: when `ir[IMM_BIT]`=1 (latched at T2), T4 asserts `c_out` instead of `r_out[rc]`. `opcode` is unchanged.
- `ALU_STEP_IMM_EN` not defined: `c_out` is tied to 0, `IMM_BIT` is ignored, and T4 always drives `r_out[rc]`.

## Test plan
- shra: `ir`=32'b00110_0001_0010_0011_000…0 (shra R1,R2,R3), `mem_rdy`=1, `start` pulse → in T3 `r_out`=16'h0004; in T4 `r_out`=16'h0008 and `opcode`=5'b00110; in T5 `r_in`=16'h0002 and `done`=1; `busy` high for 6 cycles.
- Memory wait: `mem_rdy` held low for 3 cycles in T1 → `read`/`mdr_in` high for 4 cycles, `pc_in` high for 1 cycle, `done` arrives 3 cycles later than in the shra case.
- mul: opcode 5'b01111, ra=5 → T5 has `lo_in`=1 and `r_in`=0; T6 has `zhigh_out`, `hi_in` and `done`; total 7 cycles.
- Reset mid-instruction: drop `clear` in T4 → all outputs 0 and `step`=7 without waiting for a clock edge; after release, `start` runs a clean T0.
- Out-of-range index: NREGS=8 with rb=4'hA → T3 has `r_out`=0 and `y_in`=1; the instruction still completes.
- With `ALU_STEP_IMM_EN` defined and `IMM_BIT` set → T4 has `c_out`=1 and `r_out`=0. The same stimulus without the macro → `c_out`=0 and `r_out[rc]`=1.

Source files
------------

// File: rtl/alu_step_ctrl.sv
// Control-step sequencer: fetch (T0-T2) plus one reg-reg ALU op (T3-T5, T6 for mul/div HI/LO).
// Latency: 6 cycles T0..done (7 for mul/div), plus one per mem_rdy=0 cycle in T1.
// Backpressure: stalls in T1 until mem_rdy; start ignored while busy. Optional ALU_STEP_IMM_EN: c_out replaces r_out[rc] in T4.
module alu_step_ctrl #(
  parameter int                NREGS   = 16,
  parameter int                RIDX_W  = 4,
  parameter int                OPC_W   = 5,
  parameter int                IR_W    = 32,
  parameter logic [OPC_W-1:0]  OPC_MUL = 5'b01111,
  parameter logic [OPC_W-1:0]  OPC_DIV = 5'b10000,
  parameter int                IMM_BIT = 0
) (
  input  logic              Clock,
  input  logic              clear,
  input  logic              start,
  input  logic              mem_rdy,
  input  logic [IR_W-1:0]   ir,
  output logic              busy,
  output logic              done,
  output logic [2:0]        step,
  output logic [OPC_W-1:0]  opcode,
  output logic [NREGS-1:0]  r_in,
  output logic [NREGS-1:0]  r_out,
  output logic              pc_out,
  output logic              mar_in,
  output logic              inc_pc,
  output logic              z_in,
  output logic              zlow_out,
  output logic              zhigh_out,
  output logic              pc_in,
  output logic              read,
  output logic              mdr_in,
  output logic              mdr_out,
  output logic              ir_in,
  output logic              y_in,
  output logic              hi_in,
  output logic              lo_in,
  output logic              c_out
);

  // State encoding doubles as the step number; IDLE reads as 7.
  typedef enum logic [2:0] {
    T0   = 3'd0,
    T1   = 3'd1,
    T2   = 3'd2,
    T3   = 3'd3,
    T4   = 3'd4,
    T5   = 3'd5,
    T6   = 3'd6,
    IDLE = 3'd7
  } state_t;

  localparam int OPC_LSB = IR_W - OPC_W;
  localparam int RA_LSB  = OPC_LSB - RIDX_W;
  localparam int RB_LSB  = RA_LSB - RIDX_W;
  localparam int RC_LSB  = RB_LSB - RIDX_W;

  state_t             state_q, state_d;
  logic               t1_first_q;
  logic [RIDX_W-1:0]  ra_q, rb_q, rc_q;
  logic [OPC_W-1:0]   opc_q;
  logic               muldiv;
  logic               imm_sel;
  logic               unused_ir;

  // Only the instruction fields are consumed; remaining IR bits are don't-care here.
  assign unused_ir = ^ir;

  // Index outside 0..NREGS-1 matches no bit, so the strobe vector stays zero.
  function automatic logic [NREGS-1:0] onehot(input logic [RIDX_W-1:0] idx);
    logic [NREGS-1:0] v;
    v = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (int'(idx) == i) v[i] = 1'b1;
    end
    return v;
  endfunction

  assign muldiv = (opc_q == OPC_MUL) || (opc_q == OPC_DIV);

`ifdef ALU_STEP_IMM_EN
  logic imm_q;

  // Immediate flag captured alongside the register fields.
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear)              imm_q <= 1'b0;
    else if (state_q == T2)  imm_q <= ir[IMM_BIT];
  end

  assign imm_sel = imm_q;
`else
  logic unused_imm;

  assign unused_imm = ir[IMM_BIT];
  assign imm_sel    = 1'b0;
`endif

  // State register; reset drops straight back to IDLE, nothing is resumed.
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Marks the first T1 cycle so the PC write-back happens only once per wait.
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) t1_first_q <= 1'b0;
    else        t1_first_q <= (state_q == T0);
  end

  // Capture opcode and register indices at the end of T2 (IR load step).
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      opc_q <= '0;
      ra_q  <= '0;
      rb_q  <= '0;
      rc_q  <= '0;
    end else if (state_q == T2) begin
      opc_q <= ir[IR_W-1 -: OPC_W];
      ra_q  <= ir[RA_LSB +: RIDX_W];
      rb_q  <= ir[RB_LSB +: RIDX_W];
      rc_q  <= ir[RC_LSB +: RIDX_W];
    end
  end

  // Next-state sequencing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = T0;
      T0:      state_d = T1;
      T1:      if (mem_rdy) state_d = T2;
      T2:      state_d = T3;
      T3:      state_d = T4;
      T4:      state_d = T5;
      T5:      state_d = muldiv ? T6 : IDLE;
      T6:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from state and latched fields only.
  always_comb begin
    busy      = (state_q != IDLE);
    step      = state_q;
    done      = 1'b0;
    opcode    = '0;
    r_in      = '0;
    r_out     = '0;
    pc_out    = 1'b0;
    mar_in    = 1'b0;
    inc_pc    = 1'b0;
    z_in      = 1'b0;
    zlow_out  = 1'b0;
    zhigh_out = 1'b0;
    pc_in     = 1'b0;
    read      = 1'b0;
    mdr_in    = 1'b0;
    mdr_out   = 1'b0;
    ir_in     = 1'b0;
    y_in      = 1'b0;
    hi_in     = 1'b0;
    lo_in     = 1'b0;
    c_out     = 1'b0;
    case (state_q)
      T0: begin
        pc_out = 1'b1;
        mar_in = 1'b1;
        inc_pc = 1'b1;
        z_in   = 1'b1;
      end
      T1: begin
        read     = 1'b1;
        mdr_in   = 1'b1;
        zlow_out = t1_first_q;
        pc_in    = t1_first_q;
      end
      T2: begin
        mdr_out = 1'b1;
        ir_in   = 1'b1;
      end
      T3: begin
        r_out = onehot(rb_q);
        y_in  = 1'b1;
      end
      T4: begin
        if (imm_sel) c_out = 1'b1;
        else         r_out = onehot(rc_q);
        z_in   = 1'b1;
        opcode = opc_q;
      end
      T5: begin
        zlow_out = 1'b1;
        opcode   = opc_q;
        if (muldiv) begin
          lo_in = 1'b1;
        end else begin
          r_in = onehot(ra_q);
          done = 1'b1;
        end
      end
      T6: begin
        zhigh_out = 1'b1;
        hi_in     = 1'b1;
        done      = 1'b1;
        opcode    = opc_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_step_ctrl.sv
module tb_alu_step_ctrl;

  logic        Clock = 1'b0;
  logic        clear = 1'b1;
  logic        start = 1'b0;
  logic        mem_rdy = 1'b0;
  logic [31:0] ir = '0;

  logic        busy, done, pc_out, mar_in, inc_pc, z_in, zlow_out, zhigh_out;
  logic        pc_in, read, mdr_in, mdr_out, ir_in, y_in, hi_in, lo_in, c_out;
  logic [2:0]  step;
  logic [4:0]  opcode;
  logic [15:0] r_in, r_out;

  logic        busy8, done8, y_in8;
  logic [7:0]  r_in8, r_out8;
  logic        unused8_a, unused8_b, unused8_c, unused8_d, unused8_e, unused8_f, unused8_g;
  logic        unused8_h, unused8_i, unused8_j, unused8_k, unused8_l, unused8_m, unused8_n;
  logic [2:0]  unused8_step;
  logic [4:0]  unused8_opc;

  int n_chk = 0;
  int n_err = 0;

  // Per-instruction observations
  int          busy_cnt, rd_cnt, pcin_cnt, done_cnt, done_at, multi_rout;
  logic        pcout_t0, marin_t0, yin_t3, yin8_t3, zin_t4, cout_t4;
  logic        zlow_t5, lo_t5, done_t5, hi_t6, zhigh_t6, done_t6;
  logic [15:0] rout_t3, rout_t4, rin_t5;
  logic [7:0]  rout8_t3;
  logic [4:0]  op_t4, op_t5;

  localparam logic [31:0] SHRA  = {5'b00110, 4'd1, 4'd2, 4'd3, 15'd0};
  localparam logic [31:0] MUL   = {5'b01111, 4'd5, 4'd6, 4'd7, 15'd0};
  localparam logic [31:0] DIV   = {5'b10000, 4'd5, 4'd6, 4'd7, 15'd0};
  localparam logic [31:0] OOR   = {5'b00011, 4'd1, 4'hA, 4'd2, 15'd0};
  localparam logic [31:0] SHRAI = {5'b00110, 4'd1, 4'd2, 4'd3, 15'd1};

  always #5 Clock = ~Clock;

  alu_step_ctrl u_dut (
    .Clock(Clock), .clear(clear), .start(start), .mem_rdy(mem_rdy), .ir(ir),
    .busy(busy), .done(done), .step(step), .opcode(opcode), .r_in(r_in), .r_out(r_out),
    .pc_out(pc_out), .mar_in(mar_in), .inc_pc(inc_pc), .z_in(z_in), .zlow_out(zlow_out),
    .zhigh_out(zhigh_out), .pc_in(pc_in), .read(read), .mdr_in(mdr_in), .mdr_out(mdr_out),
    .ir_in(ir_in), .y_in(y_in), .hi_in(hi_in), .lo_in(lo_in), .c_out(c_out)
  );

  alu_step_ctrl #(.NREGS(8)) u_dut8 (
    .Clock(Clock), .clear(clear), .start(start), .mem_rdy(mem_rdy), .ir(ir),
    .busy(busy8), .done(done8), .step(unused8_step), .opcode(unused8_opc), .r_in(r_in8),
    .r_out(r_out8), .pc_out(unused8_a), .mar_in(unused8_b), .inc_pc(unused8_c),
    .z_in(unused8_d), .zlow_out(unused8_e), .zhigh_out(unused8_f), .pc_in(unused8_g),
    .read(unused8_h), .mdr_in(unused8_i), .mdr_out(unused8_j), .ir_in(unused8_k),
    .y_in(y_in8), .hi_in(unused8_l), .lo_in(unused8_m), .c_out(unused8_n)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Launch one instruction from IDLE and record what each step drives.
  task automatic run_instr(input logic [31:0] instr, input int wait_n);
    int t1cnt;
    int cyc;
    busy_cnt = 0; rd_cnt = 0; pcin_cnt = 0; done_cnt = 0; done_at = 0;
    pcout_t0 = 0; marin_t0 = 0; yin_t3 = 0; yin8_t3 = 0; zin_t4 = 0; cout_t4 = 0;
    zlow_t5 = 0; lo_t5 = 0; done_t5 = 0; hi_t6 = 0; zhigh_t6 = 0; done_t6 = 0;
    rout_t3 = 0; rout_t4 = 0; rin_t5 = 0; rout8_t3 = 0; op_t4 = 0; op_t5 = 0;
    t1cnt = 0; cyc = 0;
    ir = instr; mem_rdy = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    while (busy && cyc < 40) begin
      cyc++;
      busy_cnt++;
      if (read)  rd_cnt++;
      if (pc_in) pcin_cnt++;
      if (done) begin done_cnt++; done_at = cyc; end
      if ($countones(r_out) > 1) multi_rout++;
      case (step)
        3'd0: begin pcout_t0 = pc_out; marin_t0 = mar_in; end
        3'd1: begin t1cnt++; mem_rdy = (t1cnt > wait_n); end
        3'd3: begin rout_t3 = r_out; yin_t3 = y_in; rout8_t3 = r_out8; yin8_t3 = y_in8; end
        3'd4: begin rout_t4 = r_out; op_t4 = opcode; zin_t4 = z_in; cout_t4 = c_out; end
        3'd5: begin rin_t5 = r_in; zlow_t5 = zlow_out; lo_t5 = lo_in; done_t5 = done; op_t5 = opcode; end
        3'd6: begin hi_t6 = hi_in; zhigh_t6 = zhigh_out; done_t6 = done; end
        default: ;
      endcase
      tick();
    end
    chk("no_timeout", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    multi_rout = 0;
    // Reset state
    #2 clear = 1'b0;
    #2;
    chk("rst_step", {29'd0, step}, 32'd7);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rout", {16'd0, r_out}, 32'd0);
    chk("rst_opc", {27'd0, opcode}, 32'd0);
    chk("rst_pcout", {31'd0, pc_out}, 32'd0);
    tick();
    clear = 1'b1;
    tick();

    // shra R1,R2,R3, memory ready
    run_instr(SHRA, 0);
    chk("shra_t0_pcout", {31'd0, pcout_t0}, 32'd1);
    chk("shra_t0_marin", {31'd0, marin_t0}, 32'd1);
    chk("shra_t3_rout", {16'd0, rout_t3}, 32'h0004);
    chk("shra_t3_yin", {31'd0, yin_t3}, 32'd1);
    chk("shra_t4_rout", {16'd0, rout_t4}, 32'h0008);
    chk("shra_t4_opc", {27'd0, op_t4}, 32'h06);
    chk("shra_t4_zin", {31'd0, zin_t4}, 32'd1);
    chk("shra_t5_rin", {16'd0, rin_t5}, 32'h0002);
    chk("shra_t5_done", {31'd0, done_t5}, 32'd1);
    chk("shra_t5_opc", {27'd0, op_t5}, 32'h06);
    chk("shra_t5_lo", {31'd0, lo_t5}, 32'd0);
    chk("shra_busy_cyc", busy_cnt, 32'd6);
    chk("shra_done_at", done_at, 32'd6);
    chk("shra_done_cnt", done_cnt, 32'd1);
    chk("shra_read_cyc", rd_cnt, 32'd1);
    chk("shra_pcin_cyc", pcin_cnt, 32'd1);
    chk("idle_opc", {27'd0, opcode}, 32'd0);
    chk("idle_step", {29'd0, step}, 32'd7);

    // Three wait cycles in T1
    run_instr(SHRA, 3);
    chk("wait_read_cyc", rd_cnt, 32'd4);
    chk("wait_pcin_cyc", pcin_cnt, 32'd1);
    chk("wait_done_at", done_at, 32'd9);
    chk("wait_rout_t3", {16'd0, rout_t3}, 32'h0004);

    // mul: HI/LO write-back
    run_instr(MUL, 0);
    chk("mul_t5_lo", {31'd0, lo_t5}, 32'd1);
    chk("mul_t5_rin", {16'd0, rin_t5}, 32'd0);
    chk("mul_t5_done", {31'd0, done_t5}, 32'd0);
    chk("mul_t5_zlow", {31'd0, zlow_t5}, 32'd1);
    chk("mul_t6_hi", {31'd0, hi_t6}, 32'd1);
    chk("mul_t6_zhigh", {31'd0, zhigh_t6}, 32'd1);
    chk("mul_t6_done", {31'd0, done_t6}, 32'd1);
    chk("mul_done_at", done_at, 32'd7);
    chk("mul_opc_t4", {27'd0, op_t4}, 32'h0F);

    // div takes the same path
    run_instr(DIV, 0);
    chk("div_done_at", done_at, 32'd7);
    chk("div_t6_hi", {31'd0, hi_t6}, 32'd1);

    // Out-of-range rb on the 8-register instance
    run_instr(OOR, 0);
    chk("oor8_t3_rout", {24'd0, rout8_t3}, 32'd0);
    chk("oor8_t3_yin", {31'd0, yin8_t3}, 32'd1);
    chk("oor16_t3_rout", {16'd0, rout_t3}, 32'h0400);
    chk("oor_done_at", done_at, 32'd6);
    chk("oor8_idle", {31'd0, busy8}, 32'd0);

    // Immediate flag in IR bit 0
    run_instr(SHRAI, 0);
`ifdef ALU_STEP_IMM_EN
    chk("imm_t4_cout", {31'd0, cout_t4}, 32'd1);
    chk("imm_t4_rout", {16'd0, rout_t4}, 32'd0);
`else
    chk("imm_t4_cout", {31'd0, cout_t4}, 32'd0);
    chk("imm_t4_rout", {16'd0, rout_t4}, 32'h0008);
`endif
    chk("imm_t4_opc", {27'd0, op_t4}, 32'h06);

    // Reset mid-instruction, in T4, between clock edges
    ir = SHRA; mem_rdy = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("mid_pre_step", {29'd0, step}, 32'd4);
    #2 clear = 1'b0;
    #1;
    chk("mid_step", {29'd0, step}, 32'd7);
    chk("mid_busy", {31'd0, busy}, 32'd0);
    chk("mid_rout", {16'd0, r_out}, 32'd0);
    chk("mid_zin", {31'd0, z_in}, 32'd0);
    chk("mid_opc", {27'd0, opcode}, 32'd0);
    tick();
    clear = 1'b1;
    tick();
    chk("mid_stay_idle", {29'd0, step}, 32'd7);
    run_instr(SHRA, 0);
    chk("post_rst_t0", {31'd0, pcout_t0}, 32'd1);
    chk("post_rst_done_at", done_at, 32'd6);
    chk("post_rst_rin", {16'd0, rin_t5}, 32'h0002);

    // Back-to-back: start asserted right after done
    ir = SHRA; mem_rdy = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    chk("b2b_done", {31'd0, done}, 32'd1);
    start = 1'b1;
    tick();
    chk("b2b_idle", {29'd0, step}, 32'd7);
    tick();
    start = 1'b0;
    chk("b2b_t0", {29'd0, step}, 32'd0);
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 20 && busy; i++) tick();
    chk("b2b_end_idle", {31'd0, busy}, 32'd0);

    chk("rout_onehot", multi_rout, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
